mux3_rr_arbiter: RTL and testbench

- Round-robin packet arbiter sharing one 3:1 select mux between three requesters.
- Drives the mux Select and gates a valid/ready handshake so a granted requester keeps the path until the last beat of its packet.
- Sits in front of the 3:1 data mux; the datapath itself stays outside this block.
- An idle watchdog releases a requester that stalls mid-packet.

---
 rtl/mux3_rr_arbiter.sv | 128 ++++++++++++
 tb/tb_mux3_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner selection for a shared 3:1 mux; the grant is held until the owner's last beat or a watchdog release.
// One cycle grant latency from idle, back-to-back re-grant on the last beat; the owner sees sink ready, the others see 0.
module mux3_rr_arbiter #(
  parameter int unsigned timeout = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] IN_VALID,
  input  logic [2:0] IN_LAST,
  output logic [2:0] IN_READY,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [1:0] Select,
  output logic [2:0] Grant,
  output logic       Busy,
  output logic       Forced
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(timeout);

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [2:0] grant_q, grant_d;
  logic [7:0] wd_q, wd_d;
  logic       forced_q, forced_d;

  logic       owner_vld;
  logic       owner_last;
  logic       xfer;
  logic [1:0] win;

  // Search order starts just after ptr and wraps, so ptr itself comes last.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] first;
    logic [1:0] second;
    first  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    second = (first == 2'd2) ? 2'd0 : first + 2'd1;
    if (req[first])       return first;
    else if (req[second]) return second;
    else                  return ptr;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    return 3'b001 << idx;
  endfunction

  assign owner_vld  = |(IN_VALID & grant_q);
  assign owner_last = |(IN_LAST & grant_q);
  assign xfer       = owner_vld & OUT_READY;

  assign OUT_VALID = owner_vld;
  assign IN_READY  = grant_q & {3{OUT_READY}};
  assign Select    = sel_q;
  assign Grant     = grant_q;
  assign Busy      = (state_q == GRANT);
  assign Forced    = forced_q;

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    grant_d  = grant_q;
    wd_d     = wd_q;
    forced_d = 1'b0;
    win      = rr_pick(IN_VALID, last_q);
    case (state_q)
      IDLE: begin
        if (|IN_VALID) begin
          state_d = GRANT;
          grant_d = onehot(win);
          sel_d   = win;
          last_d  = win;
          wd_d    = 8'd0;
        end
      end
      GRANT: begin
        // last_q already points at the owner, so the owner ranks lowest here.
        if (xfer && owner_last) begin
          wd_d = 8'd0;
          if (|IN_VALID) begin
            grant_d = onehot(win);
            sel_d   = win;
            last_d  = win;
          end else begin
            state_d = IDLE;
            grant_d = 3'b000;
          end
        end else if (owner_vld) begin
          wd_d = 8'd0;
        end else if ((timeout != 0) && (wd_q == TIMEOUT_C - 8'd1)) begin
          state_d  = IDLE;
          grant_d  = 3'b000;
          wd_d     = 8'd0;
          forced_d = 1'b1;
          last_d   = sel_q;
        end else if (wd_q != 8'hFF) begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      sel_q    <= 2'd0;
      last_q   <= 2'd2;
      grant_q  <= 3'b000;
      wd_q     <= 8'd0;
      forced_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      wd_q     <= wd_d;
      forced_q <= forced_d;
    end
  end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Scoreboard bench: a packet-level arbiter model queues expected per-cycle status and transfers; a negedge monitor compares.
module tb_mux3_rr_arbiter;

  localparam int TO = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [2:0] IN_VALID = 3'b000;
  logic [2:0] IN_LAST = 3'b000;
  logic       OUT_READY = 1'b0;
  logic [2:0] IN_READY;
  logic       OUT_VALID;
  logic [1:0] Select;
  logic [2:0] Grant;
  logic       Busy;
  logic       Forced;

  mux3_rr_arbiter #(.timeout(TO)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_LAST(IN_LAST),
    .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Select(Select), .Grant(Grant), .Busy(Busy), .Forced(Forced)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       forced;
    logic       ov;
    logic [2:0] rdy;
  } stat_t;

  int    checks = 0;
  int    failures = 0;
  stat_t sq[$];
  int    xq[$];
  bit    mon_en = 1'b0;

  // Reference model: owner (-1 = nobody), last served, idle-cycle count of the owner.
  int m_owner, m_last, m_stall, m_sel;
  bit m_forced;
  int rem[3];

  function automatic int pick(input logic [2:0] v, input int last);
    for (int k = 1; k <= 3; k++) begin
      if (v[(last + k) % 3]) return (last + k) % 3;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = -1; m_last = 2; m_stall = 0; m_sel = 0; m_forced = 1'b0;
  endfunction

  function automatic void take(input int w);
    m_owner = w; m_last = w; m_sel = w; m_stall = 0;
  endfunction

  function automatic int model_step(input logic [2:0] v, input logic [2:0] l, input logic r);
    int x;
    x = -1;
    m_forced = 1'b0;
    if (m_owner < 0) begin
      if (v != 3'b000) take(pick(v, m_last));
    end else if (v[m_owner] && r) begin
      x = m_owner;
      m_stall = 0;
      if (l[m_owner]) begin
        m_last = m_owner;
        if (pick(v, m_last) >= 0) take(pick(v, m_last));
        else m_owner = -1;
      end
    end else if (!v[m_owner]) begin
      m_stall++;
      if (TO > 0 && m_stall >= TO) begin
        m_last = m_owner; m_owner = -1; m_forced = 1'b1;
      end
    end else begin
      m_stall = 0;
    end
    return x;
  endfunction

  function automatic stat_t expect_now();
    stat_t e;
    e = '0;
    e.sel = m_sel[1:0];
    e.forced = m_forced;
    if (m_owner >= 0) begin
      e.grant = 3'b001 << m_owner;
      e.busy  = 1'b1;
      e.ov    = IN_VALID[m_owner];
      e.rdy   = OUT_READY ? e.grant : 3'b000;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] vmask, input int pv, input int pr);
    stat_t e;
    for (int i = 0; i < 3; i++) begin
      IN_VALID[i] = vmask[i] && ($urandom_range(99) < pv);
      IN_LAST[i]  = (rem[i] == 1);
    end
    OUT_READY = ($urandom_range(99) < pr);
    e = expect_now();
    sq.push_back(e);
    if (e.ov && OUT_READY) xq.push_back(m_owner);
  endtask

  task automatic cyc(input logic [2:0] vmask, input int pv, input int pr, input int minl, input int maxl);
    int x;
    @(posedge CLK);
    x = model_step(IN_VALID, IN_LAST, OUT_READY);
    if (x >= 0) begin
      rem[x]--;
      if (rem[x] <= 0) rem[x] = int'($urandom_range(maxl, minl));
    end
    #1;
    drive(vmask, pv, pr);
  endtask

  task automatic release_reset(input logic [2:0] vmask, input int pv, input int pr);
    model_reset();
    RESET = 1'b0;
    drive(vmask, pv, pr);
    mon_en = 1'b1;
  endtask

  always @(negedge CLK) begin : monitor
    stat_t a, e;
    int s;
    if (mon_en) begin
      a = {Grant, Select, Busy, Forced, OUT_VALID, IN_READY};
      checks++;
      if (sq.size() == 0) begin
        failures++;
        $display("FAIL status: no expected entry queued");
      end else begin
        e = sq.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL status t=%0t grant=%b sel=%0d busy=%b forced=%b ov=%b rdy=%b required grant=%b sel=%0d busy=%b forced=%b ov=%b rdy=%b",
                   $time, a.grant, a.sel, a.busy, a.forced, a.ov, a.rdy, e.grant, e.sel, e.busy, e.forced, e.ov, e.rdy);
        end
      end
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        checks++;
        if (xq.size() == 0) begin
          failures++;
          $display("FAIL transfer unexpected from sel=%0d", Select);
        end else begin
          s = xq.pop_front();
          if (Select !== s[1:0]) begin
            failures++;
            $display("FAIL transfer source actual=%0d required=%0d", Select, s);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL sim_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) rem[i] = 1;
    IN_VALID = 3'b111; IN_LAST = 3'b111; OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_grant", 32'(Grant), 0);
    chk("reset_select", 32'(Select), 0);
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_forced", 32'(Forced), 0);
    chk("reset_in_ready", 32'(IN_READY), 0);
    chk("reset_out_valid", 32'(OUT_VALID), 0);

    // Single-beat packets from everyone: 0,1,2,0... rotation.
    release_reset(3'b111, 100, 100);
    repeat (9) cyc(3'b111, 100, 100, 1, 1);

    // Four-beat packets from 0 and 1, back-to-back hand-over.
    for (int i = 0; i < 3; i++) rem[i] = 4;
    repeat (24) cyc(3'b011, 100, 100, 4, 4);

    // Sink stalls mid-packet.
    repeat (40) cyc(3'b111, 100, 40, 2, 4);

    // Sparse valids so owners stall into the watchdog.
    repeat (80) cyc(3'b101, 25, 100, 2, 3);
    repeat (40) cyc(3'b100, 30, 100, 2, 3);

    // Lone requester 0, back-to-back packets.
    repeat (20) cyc(3'b001, 100, 100, 3, 3);

    // Walk to beat 2 of a requester-1 packet, then reset asynchronously.
    rem[1] = 4;
    for (int k = 0; k < 50 && !(m_owner == 1 && rem[1] == 3); k++) cyc(3'b010, 100, 100, 4, 4);
    #2;
    RESET = 1'b1;
    mon_en = 1'b0;
    #1;
    chk("async_reset_grant", 32'(Grant), 0);
    chk("async_reset_in_ready", 32'(IN_READY), 0);
    chk("async_reset_out_valid", 32'(OUT_VALID), 0);
    chk("async_reset_busy", 32'(Busy), 0);
    sq.delete();
    xq.delete();
    for (int i = 0; i < 3; i++) rem[i] = 2;
    @(posedge CLK);
    #1;
    release_reset(3'b111, 100, 100);
    repeat (6) cyc(3'b111, 100, 100, 2, 2);

    // Random traffic with a fresh requester mask per block.
    for (int b = 0; b < 6; b++) begin
      logic [2:0] m;
      m = 3'($urandom_range(7, 1));
      repeat (400) cyc(m, 60, 70, 1, 5);
    end

    @(negedge CLK);
    #1;
    mon_en = 1'b0;
    chk("transfer_queue_drained", 32'(xq.size()), 0);
    chk("status_queue_drained", 32'(sq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
